uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Byte-wide UART serial transmitter: the transmit-side counterpart of the core's UART receiver, driving the TX pin of the debug/console UART. Accepts bytes over a valid/ready handshake into a one-entry holding register, then serialises start, 8 data bits LSB first, optional parity and 1 or 2 stop bits at `clock_divider_i` clocks per bit. The holding register allows back-to-back frames with no idle gap.

## Interface
- `CLOCK_DIVIDER_WIDTH`, 16, width of the clocks-per-bit divider.
- `clock_i`  in  1  system clock; all logic on rising edge.
- `reset_i`  in  1  asynchronous, active-low reset.
- `clock_divider_i`  in  CLOCK_DIVIDER_WIDTH  clocks per bit; must be >= 2 to transmit.
- `data_i`  in  8  byte to send.
- `valid_i`  in  1  `data_i` valid; transfer occurs on edge where `valid_i && ready_o`.
- `ready_o`  out  1  holding register empty.
- `parity_bit_i`  in  1  1 = append parity bit.
- `parity_even_i`  in  1  1 = even parity, 0 = odd.
- `two_stop_bits_i`  in  1  1 = two stop bits, 0 = one.
- `serial_o`  out  1  UART line; idle high.
- `busy_o`  out  1  frame in progress or byte held.

## Operation
- Reset (reset_i low, asynchronous): `serial_o`=1, `ready_o`=1, `busy_o`=0, holding empty, state IDLE, timers/counters 0. Takes effect immediately, including mid-frame; no partial frame resumes after release.
- Holding register: loaded on handshake; `ready_o` = !holding_full (registered flag). Cleared when transferred to shift register.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `serial_o`=1. If holding full and `clock_divider_i >= 2`: move holding to shifter, latch divider, parity_bit, parity_even, two_stop_bits; go START. If divider < 2: stay IDLE, byte stays held (`ready_o` 0, `busy_o` 1).
- Bit timer: loaded with latched divider-1 on entering each bit, counts down; bit ends on the cycle timer == 0. Every bit lasts exactly latched-divider cycles.
- START: `serial_o`=0 → DATA, bit index 0.
- DATA: `serial_o` = shifter[index]; after index 7 → PARITY if parity enabled else STOP.
- PARITY: `serial_o` = XOR(data) when even, ~XOR(data) when odd → STOP.
- STOP: `serial_o`=1 for 1 or 2 bit periods. At end: if holding full and divider >= 2, load next byte and go directly to START (no idle cycle); else IDLE.
- Config inputs and divider changes mid-frame have no effect until next frame start.
- `busy_o` = (state != IDLE) || holding_full.
- Counter widths: bit index 3 bits; stop counter 1 bit; timer CLOCK_DIVIDER_WIDTH bits, no wrap (reloaded before reaching 0-1).

## Timing
- Handshake at edge N with transmitter IDLE: holding loaded at N; state→START and `serial_o` falls at edge N+1; `ready_o` low after N, high again after N+1.
- A second byte may be accepted the cycle after `ready_o` rises; it waits in holding until the current frame's final stop bit ends.
- Frame length in cycles: D×(10 + parity + two_stop), D = latched divider.
- Back-to-back: start bit of next frame begins on the cycle immediately following the last stop-bit cycle.
- `ready_o` never asserts same edge as transfer-out; no simultaneous load and drain of holding (load requires `ready_o`=1).
- `valid_i` with `ready_o`=0 is ignored; data not captured.

## Test plan
- Divider 4, no parity, 1 stop, send 0xA5 → `serial_o` low cycles 1–4 after accept, then 1,0,1,0,0,1,0,1 each 4 cycles, high 4 cycles; `busy_o` drops after cycle 40.
- Divider 3, parity even, send 0x07 → parity bit 1; repeat odd → 0; frame 33 cycles each.
- Divider 2, `valid_i` held with 0x55 then 0xAA → second start bit immediately follows first stop bit; `ready_o` pulses high once between bytes; 40 cycles total.
- Divider 1, send 0x3C → `ready_o` 0, `busy_o` 1, `serial_o` stays 1; set divider 5 → frame starts next cycle, 50 cycles.
- Two stop bits, divider 4, send 0xFF → stop held 8 cycles; total 44 cycles.
- Reset low during DATA bit 3 → `serial_o`=1, `ready_o`=1, `busy_o`=0 same cycle without clock; after release line idle until new handshake.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
// Byte-wide UART transmitter with a one-entry holding register in front of
// the shifter, so a second byte can be queued while a frame is on the wire
// and sent with no idle gap.
//
// Ports:
//   clock_i          system clock, rising edge
//   reset_i          asynchronous active-low reset
//   clock_divider_i  clocks per bit (>= 2 to transmit), latched per frame
//   data_i/valid_i   byte input, accepted when valid_i && ready_o
//   ready_o          holding register empty
//   parity_bit_i     append parity bit (latched per frame)
//   parity_even_i    1 = even parity, 0 = odd (latched per frame)
//   two_stop_bits_i  1 = two stop bits (latched per frame)
//   serial_o         UART line, idle high
//   busy_o           frame in progress or byte held
//
// state  | meaning
// IDLE   | line high, waiting for a held byte and a usable divider
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | optional parity bit
// STOP   | one or two stop bits (high)
module uart_tx_buffered #(
  parameter int CLOCK_DIVIDER_WIDTH = 16
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
  input  logic [7:0]                     data_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic                           parity_bit_i,
  input  logic                           parity_even_i,
  input  logic                           two_stop_bits_i,
  output logic                           serial_o,
  output logic                           busy_o
);

  localparam int W = CLOCK_DIVIDER_WIDTH;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e         state_q, state_d;
  logic [7:0]     hold_q, hold_d;
  logic           hold_full_q, hold_full_d;
  logic [7:0]     shift_q, shift_d;
  logic [W-1:0]   div_q, div_d;
  logic           par_en_q, par_en_d;
  logic           par_even_q, par_even_d;
  logic           two_stop_q, two_stop_d;
  logic [W-1:0]   timer_q, timer_d;
  logic [2:0]     idx_q, idx_d;
  logic           stop_cnt_q, stop_cnt_d;

  logic           accept;
  logic           div_ok;
  logic           bit_end;
  logic           start_frame;
  logic [W-1:0]   reload;

  assign accept  = valid_i && !hold_full_q;
  assign div_ok  = clock_divider_i >= W'(2);
  assign bit_end = (timer_q == '0);
  assign reload  = div_q - W'(1);

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      div_q       <= '0;
      par_en_q    <= 1'b0;
      par_even_q  <= 1'b0;
      two_stop_q  <= 1'b0;
      timer_q     <= '0;
      idx_q       <= '0;
      stop_cnt_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      div_q       <= div_d;
      par_en_q    <= par_en_d;
      par_even_q  <= par_even_d;
      two_stop_q  <= two_stop_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      stop_cnt_q  <= stop_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    div_d       = div_q;
    par_en_d    = par_en_q;
    par_even_d  = par_even_q;
    two_stop_d  = two_stop_q;
    idx_d       = idx_q;
    stop_cnt_d  = stop_cnt_q;
    start_frame = 1'b0;
    // Timer free-runs down inside a bit; every bit_end path reloads it,
    // so it never wraps below zero.
    timer_d     = (state_q == IDLE) ? timer_q : timer_q - W'(1);

    case (state_q)
      IDLE: begin
        if (hold_full_q && div_ok) start_frame = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          timer_d = reload;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_d = reload;
          if (idx_q == 3'd7) begin
            state_d    = par_en_q ? PARITY : STOP;
            stop_cnt_d = 1'b0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
          timer_d    = reload;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (two_stop_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
            timer_d    = reload;
          end else if (hold_full_q && div_ok) begin
            // Chain straight into the next start bit, no idle cycle.
            start_frame = 1'b1;
          end else begin
            state_d = IDLE;
            timer_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_frame) begin
      state_d     = START;
      shift_d     = hold_q;
      div_d       = clock_divider_i;
      par_en_d    = parity_bit_i;
      par_even_d  = parity_even_i;
      two_stop_d  = two_stop_bits_i;
      timer_d     = clock_divider_i - W'(1);
      hold_full_d = 1'b0;
    end

    // A load needs an empty holding register and a drain needs a full one,
    // so the two can never coincide.
    if (accept) begin
      hold_d      = data_i;
      hold_full_d = 1'b1;
    end
  end

  always_comb begin
    serial_o = 1'b1;
    case (state_q)
      START:   serial_o = 1'b0;
      DATA:    serial_o = shift_q[idx_q];
      PARITY:  serial_o = (^shift_q) ^ !par_even_q;
      default: serial_o = 1'b1;
    endcase
  end

  assign ready_o = !hold_full_q;
  assign busy_o  = (state_q != IDLE) || hold_full_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered: directed scenarios plus randomized frames,
// each compared cycle by cycle against a bit-list model of the UART frame.
module tb_uart_tx_buffered;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] div;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        par_en;
  logic        par_even;
  logic        two_stop;
  logic        serial;
  logic        busy;

  int checks = 0;
  int errors = 0;

  bit exp_q[$];

  uart_tx_buffered #(.CLOCK_DIVIDER_WIDTH(16)) dut (
    .clock_i        (clk),
    .reset_i        (rst_n),
    .clock_divider_i(div),
    .data_i         (data),
    .valid_i        (valid),
    .ready_o        (ready),
    .parity_bit_i   (par_en),
    .parity_even_i  (par_even),
    .two_stop_bits_i(two_stop),
    .serial_o       (serial),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  // Frame model: list of line levels, one entry per bit period.
  function automatic void build_frame(input logic [7:0] d, input bit p, input bit ev, input bit ts);
    int ones;
    ones = $countones(d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (p) exp_q.push_back(ev ? bit'(ones % 2) : bit'(1 - ones % 2));
    exp_q.push_back(1'b1);
    if (ts) exp_q.push_back(1'b1);
  endfunction

  task automatic set_cfg(input int d, input bit p, input bit ev, input bit ts);
    @(negedge clk);
    div = 16'(d); par_en = p; par_even = ev; two_stop = ts;
  endtask

  task automatic do_accept(input logic [7:0] d, input string name);
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_accept: got %b want 1", name, ready);
    end
    data = d; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    checks++;
    if (ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s after_accept: ready=%b busy=%b want ready=0 busy=1", name, ready, busy);
    end
  endtask

  // Walks the modelled frame(s) one clock at a time, starting at the edge
  // where the start bit is expected to begin.
  task automatic check_frame(input int d, input string name, input bit scramble);
    int n;
    n = exp_q.size() * d;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      checks++;
      if (serial !== exp_q[k / d] || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s serial cycle %0d: serial=%b busy=%b want serial=%b busy=1",
                 name, k, serial, busy, exp_q[k / d]);
      end
      if (k == 0) begin
        checks++;
        if (ready !== 1'b1) begin
          errors++;
          $display("FAIL %s ready_after_start: got %b want 1", name, ready);
        end
        if (scramble) begin
          div = 16'($urandom_range(1, 9));
          par_en = 1'($urandom); par_even = 1'($urandom); two_stop = 1'($urandom);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic check_idle(input string name);
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || serial !== 1'b1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle: busy=%b serial=%b ready=%b want 0 1 1", name, busy, serial, ready);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (serial !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: serial=%b ready=%b busy=%b want 1 1 0", serial, ready, busy);
    end
    @(negedge clk); rst_n = 1'b1;
    check_idle("reset_release");
  endtask

  task automatic test_basic();
    set_cfg(4, 0, 0, 0);
    build_frame(8'hA5, 0, 0, 0);
    do_accept(8'hA5, "basic_a5");
    check_frame(4, "basic_a5", 0);
    check_idle("basic_a5");
  endtask

  task automatic test_parity();
    set_cfg(3, 1, 1, 0);
    build_frame(8'h07, 1, 1, 0);
    do_accept(8'h07, "parity_even");
    check_frame(3, "parity_even", 0);
    check_idle("parity_even");
    set_cfg(3, 1, 0, 0);
    build_frame(8'h07, 1, 0, 0);
    do_accept(8'h07, "parity_odd");
    check_frame(3, "parity_odd", 0);
    check_idle("parity_odd");
  endtask

  task automatic test_back_to_back();
    int highs;
    highs = 0;
    set_cfg(2, 0, 0, 0);
    build_frame(8'h55, 0, 0, 0);
    build_frame(8'hAA, 0, 0, 0);
    @(negedge clk);
    data = 8'h55; valid = 1'b1;
    @(posedge clk); #1;
    data = 8'hAA;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      checks++;
      if (serial !== exp_q[k / 2] || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b serial cycle %0d: serial=%b busy=%b want serial=%b busy=1",
                 k, serial, busy, exp_q[k / 2]);
      end
      if (k < 20 && ready === 1'b1) highs++;
      if (k == 1) valid = 1'b0;
    end
    checks++;
    if (highs != 1) begin
      errors++;
      $display("FAIL b2b ready_pulse: high cycles=%0d want 1", highs);
    end
    exp_q.delete();
    check_idle("b2b");
  endtask

  task automatic test_bad_divider();
    set_cfg(1, 0, 0, 0);
    do_accept(8'h3C, "div1");
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b0 || busy !== 1'b1 || serial !== 1'b1) begin
        errors++;
        $display("FAIL div1 hold cycle %0d: ready=%b busy=%b serial=%b want 0 1 1", k, ready, busy, serial);
      end
    end
    set_cfg(5, 0, 0, 0);
    build_frame(8'h3C, 0, 0, 0);
    check_frame(5, "div5", 0);
    check_idle("div5");
  endtask

  task automatic test_two_stop();
    set_cfg(4, 0, 0, 1);
    build_frame(8'hFF, 0, 0, 1);
    do_accept(8'hFF, "two_stop");
    check_frame(4, "two_stop", 0);
    check_idle("two_stop");
  endtask

  task automatic test_random();
    logic [7:0] d;
    int dv;
    bit p, ev, ts;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      dv = $urandom_range(2, 6);
      p = 1'($urandom); ev = 1'($urandom); ts = 1'($urandom);
      set_cfg(dv, p, ev, ts);
      build_frame(d, p, ev, ts);
      do_accept(d, "random");
      check_frame(dv, "random", 1);
      check_idle("random");
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'($urandom) & 8'hF7;
    set_cfg(4, 0, 0, 0);
    do_accept(d, "rst_mid");
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin data = 8'h81; valid = 1'b1; end
      if (k == 2) begin
        valid = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
          errors++;
          $display("FAIL rst_mid second_held: ready=%b want 0", ready);
        end
      end
    end
    checks++;
    if (serial !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid data_bit3: serial=%b want 0", serial);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (serial !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid async: serial=%b ready=%b busy=%b want 1 1 0", serial, ready, busy);
    end
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 30; k++) check_idle("rst_mid_after");
    set_cfg(2, 1, 1, 0);
    build_frame(8'hC3, 1, 1, 0);
    do_accept(8'hC3, "rst_recover");
    check_frame(2, "rst_recover", 0);
    check_idle("rst_recover");
  endtask

  initial begin
    rst_n = 1'b0; div = 16'd4; data = 8'h00; valid = 1'b0;
    par_en = 1'b0; par_even = 1'b0; two_stop = 1'b0;
    #3;
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_bad_divider();
    test_two_stop();
    test_random();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
